// File: rtl/png_stream_sched.sv
// Shares one PNG decoder between N_SRC byte-stream sources, one whole file at a time.
// Tracks decoded pixels against the frame size and recovers stalled files via a watchdog.
module png_stream_sched #(
  parameter int          N_SRC   = 4,
  parameter int          SRC_W   = $clog2(N_SRC),
  parameter logic [31:0] TIMEOUT = 32'd65535
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_SRC-1:0]   s_ivalid,
  output logic [N_SRC-1:0]   s_iready,
  input  logic [8*N_SRC-1:0] s_ibyte,
  input  logic [N_SRC-1:0]   s_ilast,
  output logic               d_rst,
  output logic               d_ivalid,
  input  logic               d_iready,
  output logic [7:0]         d_ibyte,
  input  logic               d_newframe,
  input  logic [13:0]        d_width,
  input  logic [31:0]        d_height,
  input  logic               d_ovalid,
  output logic [SRC_W-1:0]   osrc,
  output logic               oframe_done,
  output logic               otimeout,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STREAM  = 3'd1,
    DRAIN   = 3'd2,
    RECOVER = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SRC_W-1:0] r_gnt;
  logic [SRC_W-1:0] r_rr_ptr;
  logic             r_fdone;
  logic             r_lastseen;
  logic [13:0]      r_fw;
  logic [13:0]      r_col;
  logic [31:0]      r_fh;
  logic [31:0]      r_row;
  logic [31:0]      r_wdog;
  logic             r_frame_done;
  logic             r_timeout;
  logic [1:0]       r_rst_cnt;
  logic             r_rec_cnt;

  logic [SRC_W-1:0] w_idx;
  logic [SRC_W-1:0] w_sel;
  logic             w_any;
  logic             w_grant;
  logic [7:0]       w_src_byte;
  logic             w_track;
  logic             w_hs;
  logic             w_last_hs;
  logic             w_zero_frame;
  logic             w_col_end;
  logic             w_complete;
  logic             w_act;
  logic             w_wd_fire;

  // Round-robin search starting at r_rr_ptr, wrapping at N_SRC.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_idx = SRC_W'((int'(r_rr_ptr) + i) % N_SRC);
      if (!w_any && s_ivalid[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // No grant while the decoder is still held in its post-reset window.
  assign w_grant      = w_any && (r_rst_cnt == 2'd0);
  assign w_src_byte   = s_ibyte[{r_gnt, 3'b000} +: 8];
  assign w_track      = (r_state == STREAM) || (r_state == DRAIN);
  assign w_hs         = (r_state == STREAM) && s_ivalid[r_gnt] && d_iready;
  assign w_last_hs    = w_hs && s_ilast[r_gnt];
  assign w_zero_frame = (d_width == 14'd0) || (d_height == 32'd0);
  assign w_col_end    = (r_col == r_fw - 14'd1);
  assign w_complete   = w_track && (d_newframe ? w_zero_frame
                        : (d_ovalid && w_col_end && (r_row == r_fh - 32'd1)));
  assign w_act        = w_hs || d_ovalid || d_newframe;
  assign w_wd_fire    = w_track && !w_act && (r_wdog == TIMEOUT - 32'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_iready    = '0;
    d_ivalid    = 1'b0;
    d_ibyte     = 8'd0;
    case (r_state)
      IDLE: begin
        if (w_grant) w_state_nxt = STREAM;
      end
      STREAM: begin
        d_ivalid        = s_ivalid[r_gnt];
        d_ibyte         = w_src_byte;
        s_iready[r_gnt] = d_iready;
        if (w_wd_fire)      w_state_nxt = RECOVER;
        else if (w_last_hs) w_state_nxt = (r_fdone || w_complete) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (w_wd_fire)       w_state_nxt = RECOVER;
        else if (w_complete) w_state_nxt = IDLE;
      end
      RECOVER: begin
        if (r_rec_cnt) w_state_nxt = r_lastseen ? IDLE : FLUSH;
      end
      FLUSH: begin
        s_iready[r_gnt] = 1'b1;
        if (s_ivalid[r_gnt] && s_ilast[r_gnt]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt        <= '0;
      r_rr_ptr     <= '0;
      r_fdone      <= 1'b0;
      r_lastseen   <= 1'b0;
      r_fw         <= 14'd0;
      r_fh         <= 32'd0;
      r_col        <= 14'd0;
      r_row        <= 32'd0;
      r_wdog       <= 32'd0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
      r_rst_cnt    <= 2'd2;
      r_rec_cnt    <= 1'b0;
    end else begin
      r_frame_done <= w_complete;
      r_timeout    <= w_wd_fire;
      r_rec_cnt    <= (r_state == RECOVER) && !r_rec_cnt;
      if (r_rst_cnt != 2'd0) r_rst_cnt <= r_rst_cnt - 2'd1;
      if (r_state == IDLE && w_grant) begin
        r_gnt      <= w_sel;
        r_rr_ptr   <= SRC_W'((int'(w_sel) + 1) % N_SRC);
        r_fdone    <= 1'b0;
        r_lastseen <= 1'b0;
        r_fw       <= 14'd0;
        r_fh       <= 32'd0;
        r_col      <= 14'd0;
        r_row      <= 32'd0;
        r_wdog     <= 32'd0;
      end
      if (w_track) begin
        if (d_newframe) begin
          r_fw  <= d_width;
          r_fh  <= d_height;
          r_col <= 14'd0;
          r_row <= 32'd0;
        end else if (d_ovalid) begin
          if (w_col_end) begin
            r_col <= 14'd0;
            r_row <= r_row + 32'd1;
          end else begin
            r_col <= r_col + 14'd1;
          end
        end
        if (w_complete) r_fdone <= 1'b1;
        if (w_last_hs)  r_lastseen <= 1'b1;
        r_wdog <= w_act ? 32'd0 : r_wdog + 32'd1;
      end
    end
  end

  assign d_rst       = (r_rst_cnt != 2'd0) || (r_state == RECOVER);
  assign osrc        = r_gnt;
  assign oframe_done = r_frame_done;
  assign otimeout    = r_timeout;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_png_stream_sched.sv
// Directed bench for png_stream_sched: grant, rotation, trailing bytes, backpressure,
// watchdog recovery, zero-size frames and asynchronous reset mid-file.
module tb_png_stream_sched;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] s_ivalid = '0;
  logic [N-1:0] s_iready;
  logic [8*N-1:0] s_ibyte = '0;
  logic [N-1:0] s_ilast = '0;
  logic         d_rst;
  logic         d_ivalid;
  logic         d_iready = 1'b0;
  logic [7:0]   d_ibyte;
  logic         d_newframe = 1'b0;
  logic [13:0]  d_width = '0;
  logic [31:0]  d_height = '0;
  logic         d_ovalid = 1'b0;
  logic [1:0]   osrc;
  logic         oframe_done;
  logic         otimeout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  png_stream_sched #(.N_SRC(N), .TIMEOUT(32'd100)) dut (
    .clk(clk), .rstn(rstn),
    .s_ivalid(s_ivalid), .s_iready(s_iready), .s_ibyte(s_ibyte), .s_ilast(s_ilast),
    .d_rst(d_rst), .d_ivalid(d_ivalid), .d_iready(d_iready), .d_ibyte(d_ibyte),
    .d_newframe(d_newframe), .d_width(d_width), .d_height(d_height), .d_ovalid(d_ovalid),
    .osrc(osrc), .oframe_done(oframe_done), .otimeout(otimeout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int c;
    int n;
    logic found;
    int ord [4];
    ord = '{0, 1, 3, 0};

    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy",     32'(busy), 0);
    chk("rst_iready",   32'(s_iready), 0);
    chk("rst_divalid",  32'(d_ivalid), 0);
    chk("rst_dibyte",   32'(d_ibyte), 0);
    chk("rst_fdone",    32'(oframe_done), 0);
    chk("rst_tmo",      32'(otimeout), 0);
    chk("rst_osrc",     32'(osrc), 0);
    chk("rst_drst",     32'(d_rst), 1);
    rstn = 1'b1;
    tick();
    chk("rel_drst_c1", 32'(d_rst), 1);
    tick();
    chk("rel_drst_c2", 32'(d_rst), 0);

    // ---------------- single file from source 2, 4x3 frame ----------------
    s_ivalid = 4'b0100;
    s_ibyte[23:16] = 8'h50;
    d_iready = 1'b1;
    settle();
    chk("t1_idle_busy",   32'(busy), 0);
    chk("t1_idle_iready", 32'(s_iready), 0);
    tick();
    for (int b = 0; b < 6; b++) begin
      s_ibyte[23:16] = 8'(8'h50 + b);
      s_ilast[2] = (b == 5);
      settle();
      chk("t1_iready", 32'(s_iready), 32'h4);
      chk("t1_dibyte", 32'(d_ibyte), 32'(8'h50 + b));
      chk("t1_osrc",   32'(osrc), 2);
      tick();
    end
    s_ivalid = '0;
    s_ilast = '0;
    d_newframe = 1'b1;
    d_width = 14'd4;
    d_height = 32'd3;
    settle();
    chk("t1_drain_iready", 32'(s_iready), 0);
    chk("t1_drain_divalid", 32'(d_ivalid), 0);
    chk("t1_drain_busy",   32'(busy), 1);
    tick();
    d_newframe = 1'b0;
    for (int p = 0; p < 12; p++) begin
      d_ovalid = 1'b1;
      settle();
      chk("t1_pix_osrc",  32'(osrc), 2);
      chk("t1_pix_fdone", 32'(oframe_done), 0);
      tick();
    end
    d_ovalid = 1'b0;
    settle();
    chk("t1_fdone_pulse", 32'(oframe_done), 1);
    chk("t1_end_busy",    32'(busy), 0);
    tick();
    chk("t1_fdone_once",  32'(oframe_done), 0);
    chk("t1_still_idle",  32'(busy), 0);

    // ---------------- trailing bytes + backpressure, source 1 ----------------
    s_ivalid = 4'b0010;
    s_ibyte[15:8] = 8'hA0;
    d_iready = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      s_ibyte[15:8] = 8'(8'hA0 + b);
      settle();
      chk("t2_iready", 32'(s_iready), 32'h2);
      chk("t2_dibyte", 32'(d_ibyte), 32'(8'hA0 + b));
      tick();
    end
    d_iready = 1'b0;
    s_ibyte[15:8] = 8'hA4;
    d_newframe = 1'b1;
    d_width = 14'd2;
    d_height = 32'd1;
    tick();
    d_newframe = 1'b0;
    d_ovalid = 1'b1;
    tick();
    settle();
    chk("t2_pix1_fdone", 32'(oframe_done), 0);
    tick();
    d_ovalid = 1'b0;
    settle();
    chk("t2_early_fdone", 32'(oframe_done), 1);
    chk("t2_early_busy",  32'(busy), 1);
    chk("t2_early_osrc",  32'(osrc), 1);
    k = 4;
    c = 0;
    while (k < 16 && c < 64) begin
      d_iready = (c % 2 == 0);
      s_ibyte[15:8] = 8'(8'hA0 + k);
      s_ilast[1] = (k == 15);
      settle();
      chk("t2_bp_iready", 32'(s_iready), d_iready ? 32'h2 : 32'h0);
      chk("t2_bp_dibyte", 32'(d_ibyte), 32'(8'hA0 + k));
      chk("t2_bp_busy",   32'(busy), 1);
      tick();
      if (d_iready) k++;
      c++;
    end
    chk("t2_bytes_taken", 32'(k), 16);
    s_ivalid = '0;
    s_ilast = '0;
    d_iready = 1'b1;
    settle();
    chk("t2_end_busy", 32'(busy), 0);

    // ---------------- watchdog, source 3 ----------------
    s_ivalid = 4'b1000;
    s_ibyte[31:24] = 8'd0;
    tick();
    for (int b = 0; b < 50; b++) begin
      s_ibyte[31:24] = 8'(b);
      tick();
    end
    d_iready = 1'b0;
    s_ibyte[31:24] = 8'd50;
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      tick();
      n++;
      if (otimeout) found = 1'b1;
    end
    chk("wd_idle_cycles", 32'(n), 100);
    chk("wd_drst_c1",     32'(d_rst), 1);
    chk("wd_iready_rec",  32'(s_iready), 0);
    tick();
    chk("wd_tmo_pulse",   32'(otimeout), 0);
    chk("wd_drst_c2",     32'(d_rst), 1);
    tick();
    chk("wd_drst_off",    32'(d_rst), 0);
    chk("wd_flush_iready", 32'(s_iready), 32'h8);
    chk("wd_flush_divalid", 32'(d_ivalid), 0);
    for (int b = 50; b < 56; b++) begin
      s_ibyte[31:24] = 8'(b);
      s_ilast[3] = (b == 55);
      settle();
      chk("wd_flush_acc", 32'(s_iready), 32'h8);
      tick();
    end
    s_ivalid = '0;
    s_ilast = '0;
    settle();
    chk("wd_end_busy", 32'(busy), 0);

    // ---------------- reset mid-file, source 2 ----------------
    s_ivalid = 4'b0100;
    s_ibyte[23:16] = 8'h11;
    d_iready = 1'b1;
    tick();
    tick();
    settle();
    chk("mr_osrc_pre", 32'(osrc), 2);
    chk("mr_busy_pre", 32'(busy), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mr_busy",    32'(busy), 0);
    chk("mr_iready",  32'(s_iready), 0);
    chk("mr_divalid", 32'(d_ivalid), 0);
    chk("mr_dibyte",  32'(d_ibyte), 0);
    chk("mr_osrc",    32'(osrc), 0);
    chk("mr_drst",    32'(d_rst), 1);
    s_ivalid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    chk("mr_drst_c1", 32'(d_rst), 1);
    tick();
    chk("mr_drst_c2", 32'(d_rst), 0);
    chk("mr_idle",    32'(busy), 0);

    // ---------------- round-robin with zero-size frames ----------------
    s_ivalid = 4'b1011;
    s_ilast = 4'b1111;
    s_ibyte = {8'h33, 8'h22, 8'h11, 8'h00};
    d_iready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      tick();
      settle();
      chk("rr_osrc",      32'(osrc), 32'(ord[g]));
      chk("rr_iready_bp", 32'(s_iready), 0);
      chk("rr_dibyte",    32'(d_ibyte), 32'(ord[g] * 8'h11));
      d_newframe = 1'b1;
      d_width = 14'd0;
      d_height = 32'd5;
      tick();
      d_newframe = 1'b0;
      d_iready = 1'b1;
      settle();
      chk("rr_zero_fdone", 32'(oframe_done), 1);
      chk("rr_iready",     32'(s_iready), 32'(1 << ord[g]));
      chk("rr_busy",       32'(busy), 1);
      tick();
      d_iready = 1'b0;
      settle();
      chk("rr_idle", 32'(busy), 0);
    end
    s_ivalid = '0;
    s_ilast = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/png_stream_sched.md
# png_stream_sched

Scheduler that shares one `png_decoder` instance between `N_SRC` independent PNG byte-stream sources. It grants the decoder to one source for a whole PNG file and forwards that source's bytes over the decoder's valid/ready input. It tracks the decoded pixel count against the reported frame size to decide when the file is finished, and tags output pixels with the owning source index. A watchdog detects stalled files and forces decoder recovery.

## Interface
Parameters:
- `N_SRC`, default 4: number of byte-stream sources, 2..16.
- `SRC_W`, default `$clog2(N_SRC)`: width of the source index.
- `TIMEOUT`, default 65535: idle cycles tolerated while a file is owned; 32-bit.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `rstn`  in  1  — reset, asynchronous, active-low.
- `s_ivalid`  in  N_SRC  — per-source byte valid.
- `s_iready`  out  N_SRC  — per-source byte ready.
- `s_ibyte`  in  8*N_SRC  — per-source byte; source k uses bits [8k+7:8k].
- `s_ilast`  in  N_SRC  — marks the last byte of a PNG file; qualified by valid.
- `d_rst`  out  1  — active-high reset to the decoder.
- `d_ivalid`  out  1  — decoder byte valid.
- `d_iready`  in  1  — decoder byte ready.
- `d_ibyte`  out  8  — decoder byte.
- `d_newframe`  in  1  — decoder frame-header pulse.
- `d_width`  in  14  — frame width, sampled on `d_newframe`.
- `d_height`  in  32  — frame height, sampled on `d_newframe`.
- `d_ovalid`  in  1  — decoder pixel valid.
- `osrc`  out  SRC_W  — owning source index; valid whenever `d_ovalid` is high.
- `oframe_done`  out  1  — one-cycle pulse after the last pixel of a frame.
- `otimeout`  out  1  — one-cycle pulse when the watchdog fires.
- `busy`  out  1  — high in any state other than IDLE.

## Operation
- States: IDLE, STREAM, DRAIN, RECOVER, FLUSH.
- **IDLE**
  - Select the first index with `s_ivalid` set, searching from `rr_ptr` upward with wrap.
  - Register the selection as `gnt`, clear `fdone`, `lastseen` and the counters, then go to STREAM.
  - `rr_ptr` is set to `gnt+1` (mod N_SRC) when the grant is taken.
- **STREAM**
  - Datapath: `d_ivalid = s_ivalid[gnt]`, `d_ibyte = s_ibyte[gnt]`, `s_iready[gnt] = d_iready`. All other `s_iready` bits are 0.
  - On a handshake with `s_ilast[gnt]` set:
    - if `fdone` is already set, go to IDLE;
    - otherwise go to DRAIN.
- **DRAIN**
  - `d_ivalid = 0`; all `s_iready` bits are 0.
  - Go to IDLE on frame completion.
- **Frame tracking** (STREAM and DRAIN)
  - `d_newframe` loads `fw`/`fh` and clears column counter `col` (14 b) and row counter `row` (32 b).
  - Each `d_ovalid`:
    - `col` increments;
    - at `col == fw-1`, `col` wraps to 0 and `row` increments.
  - Completion is the `d_ovalid` with `col == fw-1 && row == fh-1`. It sets `fdone` and pulses `oframe_done` on the next cycle.
  - A `d_newframe` with `d_width == 0` or `d_height == 0` is complete immediately: `oframe_done` pulses on the next cycle.
  - A second `d_newframe` within one file restarts tracking. Every completion pulses `oframe_done`.
- **Watchdog** (STREAM and DRAIN)
  - A 32-bit counter clears on any input handshake, `d_ovalid` or `d_newframe`, and increments otherwise.
  - When it reaches `TIMEOUT`: pulse `otimeout`, then go to RECOVER.
- **RECOVER**
  - `d_rst = 1` for exactly 2 cycles.
  - Then go to FLUSH if the last byte has not yet been accepted; otherwise go to IDLE.
- **FLUSH**
  - `s_iready[gnt] = 1`; bytes are discarded; `d_ivalid = 0`.
  - Go to IDLE on the handshake carrying `s_ilast`.
  - The watchdog does not run in FLUSH.
- `osrc` equals `gnt`. It is unchanged from the STREAM entry until the next grant.

## Timing
- Reset values:
  - state = IDLE, `gnt = 0`, `rr_ptr = 0`, `osrc = 0`;
  - `s_iready = 0`, `d_ivalid = 0`, `d_ibyte = 0`;
  - `oframe_done = 0`, `otimeout = 0`, `busy = 0`;
  - `d_rst = 1` while `rstn` is low, and for 2 cycles after deassertion.
- Grant latency: a request seen in IDLE at edge t gives STREAM and a forwarded `s_iready` from cycle t+1.
- Byte path is combinational from `d_iready` to `s_iready` and from `s_ibyte` to `d_ibyte`: zero added latency, no bubbles.
- Minimum one IDLE cycle between consecutive files.
- `oframe_done` occurs one cycle after the completing `d_ovalid`.
- Ordering cases:
  - Completion and the `ilast` handshake in the same cycle: go to IDLE.
  - Completion before `ilast`: remain in STREAM until `ilast`, then go to IDLE.
- A `d_ovalid` in IDLE is ignored and does not advance the counters.
- `rstn` asserted mid-file:
  - all state clears immediately;
  - the partial file is abandoned;
  - the source is not flushed.

## Test plan
- **Single file, fair grant.** Source 2 streams a 4x3 RGBA PNG with `ilast`; the decoder model emits 12 pixels.
  - Expect 12 `d_ovalid` with `osrc = 2`, and `oframe_done` once, 1 cycle after the 12th pixel.
  - Then IDLE and `busy = 0`.
- **Round-robin rotation.** Sources 0, 1 and 3 all request continuously.
  - Expect grant order 0, 1, 3, 0.
  - No `s_iready` is ever set for a non-granted source.
- **Trailing bytes.** All pixels complete 12 bytes before `ilast`.
  - Expect `oframe_done` while in STREAM, and IDLE only after the `ilast` handshake.
- **Backpressure.** `d_iready` toggles 1,0,1,0.
  - Expect `s_iready[gnt]` to track it cycle for cycle, with the byte sequence unchanged at the decoder.
- **Watchdog.** With `TIMEOUT = 100`, the decoder stalls after 50 bytes while the source holds valid.
  - Expect `otimeout` at idle cycle 100, and `d_rst` high for 2 cycles.
  - Then FLUSH accepts the remaining bytes through `ilast`, then IDLE.
- **Zero-size frame and reset mid-file.**
  - `d_newframe` with `d_width = 0` gives `oframe_done` on the next cycle.
  - A separate run pulls `rstn` low mid-STREAM: all outputs go to their reset values asynchronously, and `d_rst` stays high for 2 cycles after release.
